// File: rtl/cci_mpf_active_req_tracker_if.sv
// Request/retire pulses from the MPF/AFU edge and the tracker's status outputs.
// The master drives the per-channel pulses and control strobes; the tracker is the slave.
interface cci_mpf_active_req_tracker_if #(
  parameter int N_CHANNELS = 2,
  parameter int CNT_WIDTH  = 11
);
  logic [N_CHANNELS-1:0]           incr;
  logic [N_CHANNELS-1:0]           decr;
  logic                            drain_req;
  logic                            clr_peak;
  logic                            clr_err;

  logic [N_CHANNELS-1:0]           not_empty;
  logic [N_CHANNELS-1:0]           throttle;
  logic [N_CHANNELS*CNT_WIDTH-1:0] active_cnt;
  logic [N_CHANNELS*CNT_WIDTH-1:0] peak_cnt;
  logic                            drain_ack;
  logic [N_CHANNELS-1:0]           err_underflow;
  logic [N_CHANNELS-1:0]           err_overflow;

  modport master (
    output incr, decr, drain_req, clr_peak, clr_err,
    input  not_empty, throttle, active_cnt, peak_cnt, drain_ack,
           err_underflow, err_overflow
  );

  modport slave (
    input  incr, decr, drain_req, clr_peak, clr_err,
    output not_empty, throttle, active_cnt, peak_cnt, drain_ack,
           err_underflow, err_overflow
  );
endinterface

// File: rtl/cci_mpf_active_req_tracker.sv
// Per-channel in-flight request tracker: saturating counters, throttle,
// high-water marks, sticky under/overflow flags and a drain (quiesce) handshake.
module cci_mpf_active_req_tracker #(
  parameter int N_CHANNELS      = 2,
  parameter int CNT_WIDTH       = 11,
  parameter int MAX_ACTIVE      = 1024,
  parameter int ENABLE_THROTTLE = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  cci_mpf_active_req_tracker_if.slave trk
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAINING,
    ST_DRAINED
  } drain_state_e;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  localparam cnt_t MAX_C  = cnt_t'(MAX_ACTIVE);
  localparam bit   THR_EN = (ENABLE_THROTTLE != 0);

  if (longint'(MAX_ACTIVE) > ((longint'(1) << CNT_WIDTH) - 1)) begin : g_param_check
    $error("MAX_ACTIVE (%0d) does not fit in CNT_WIDTH (%0d) bits", MAX_ACTIVE, CNT_WIDTH);
  end

  drain_state_e state, state_nxt;

  cnt_t [N_CHANNELS-1:0]  cnt_q, cnt_nxt;
  cnt_t [N_CHANNELS-1:0]  peak_q, peak_nxt;
  logic [N_CHANNELS-1:0]  not_empty_q, not_empty_nxt;
  logic [N_CHANNELS-1:0]  throttle_q, throttle_nxt;
  logic [N_CHANNELS-1:0]  err_unf_q, err_ovf_q;
  logic [N_CHANNELS-1:0]  unf_set, ovf_set;
  logic                   drain_ack_q, drain_ack_nxt;
  logic                   drain_hold;
  logic                   all_empty_nxt;

  // Per-channel counter update; saturates at both ends and reports the attempt.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    cnt_nxt       = cnt_q;
    unf_set       = '0;
    ovf_set       = '0;
    not_empty_nxt = '0;
    peak_nxt      = peak_q;
    for (int i = 0; i < N_CHANNELS; i++) begin
      case ({trk.incr[i], trk.decr[i]})
        2'b10: begin
          if (cnt_q[i] == '1) ovf_set[i] = 1'b1;
          else                cnt_nxt[i] = cnt_q[i] + cnt_t'(1);
        end
        2'b01: begin
          if (cnt_q[i] == '0) unf_set[i] = 1'b1;
          else                cnt_nxt[i] = cnt_q[i] - cnt_t'(1);
        end
        default: ;
      endcase
      not_empty_nxt[i] = trk.incr[i] | (cnt_q[i] != '0);
      if (trk.clr_peak || (cnt_nxt[i] > peak_q[i])) peak_nxt[i] = cnt_nxt[i];
    end
    all_empty_nxt = (cnt_nxt == '0);
  end

  // Drain FSM: state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Drain FSM: next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (trk.drain_req) state_nxt = ST_DRAINING;
      end
      ST_DRAINING: begin
        if (!trk.drain_req)    state_nxt = ST_IDLE;
        else if (all_empty_nxt) state_nxt = ST_DRAINED;
      end
      ST_DRAINED: begin
        if (!trk.drain_req)     state_nxt = ST_IDLE;
        else if (!all_empty_nxt) state_nxt = ST_DRAINING;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Drain FSM: outputs. Keyed on the next state so they land with the transition.
  always_comb begin
    drain_ack_nxt = (state_nxt == ST_DRAINED);
    drain_hold    = (state_nxt != ST_IDLE);
  end

  always_comb begin
    throttle_nxt = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      throttle_nxt[i] = (THR_EN && (cnt_nxt[i] >= MAX_C)) || drain_hold;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      peak_q      <= '0;
      not_empty_q <= '0;
      throttle_q  <= '0;
      err_unf_q   <= '0;
      err_ovf_q   <= '0;
      drain_ack_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_nxt;
      peak_q      <= peak_nxt;
      not_empty_q <= not_empty_nxt;
      throttle_q  <= throttle_nxt;
      // A new error in the clearing cycle keeps its bit set.
      err_unf_q   <= (err_unf_q & ~{N_CHANNELS{trk.clr_err}}) | unf_set;
      err_ovf_q   <= (err_ovf_q & ~{N_CHANNELS{trk.clr_err}}) | ovf_set;
      drain_ack_q <= drain_ack_nxt;
    end
  end

  assign trk.not_empty     = not_empty_q;
  assign trk.throttle      = throttle_q;
  assign trk.active_cnt    = cnt_q;
  assign trk.peak_cnt      = peak_q;
  assign trk.drain_ack     = drain_ack_q;
  assign trk.err_underflow = err_unf_q;
  assign trk.err_overflow  = err_ovf_q;

endmodule

// File: tb/tb_cci_mpf_active_req_tracker.sv
// Directed bench for cci_mpf_active_req_tracker: 2 channels, 3-bit counters, throttle at 4.
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
module tb_cci_mpf_active_req_tracker;

  localparam int NC = 2;
  localparam int CW = 3;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  cci_mpf_active_req_tracker_if #(.N_CHANNELS(NC), .CNT_WIDTH(CW)) bus ();

  cci_mpf_active_req_tracker #(
    .N_CHANNELS     (NC),
    .CNT_WIDTH      (CW),
    .MAX_ACTIVE     (4),
    .ENABLE_THROTTLE(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .trk  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of incr/decr, then wait until just after the capturing edge.
  task automatic drive(input logic [1:0] inc, input logic [1:0] dec);
    bus.incr = inc;
    bus.decr = dec;
    @(posedge clk);
    #1;
    bus.incr     = '0;
    bus.decr     = '0;
    bus.clr_peak = 1'b0;
    bus.clr_err  = 1'b0;
  endtask

  function automatic logic [CW-1:0] cnt_of(input int ch);
    return bus.active_cnt[ch*CW +: CW];
  endfunction

  function automatic logic [CW-1:0] peak_of(input int ch);
    return bus.peak_cnt[ch*CW +: CW];
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_cnt"},       bus.active_cnt,    32'h0);
    check({tag, "_peak"},      bus.peak_cnt,      32'h0);
    check({tag, "_not_empty"}, bus.not_empty,     32'h0);
    check({tag, "_throttle"},  bus.throttle,      32'h0);
    check({tag, "_drain_ack"}, bus.drain_ack,     32'h0);
    check({tag, "_err_unf"},   bus.err_underflow, 32'h0);
    check({tag, "_err_ovf"},   bus.err_overflow,  32'h0);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    bus.incr      = '0;
    bus.decr      = '0;
    bus.drain_req = 1'b0;
    bus.clr_peak  = 1'b0;
    bus.clr_err   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Five requests on ch0: count, peak and not_empty follow; ch1 untouched.
    repeat (5) drive(2'b01, 2'b00);
    check("t1_cnt0",      cnt_of(0),     32'd5);
    check("t1_cnt1",      cnt_of(1),     32'd0);
    check("t1_peak0",     peak_of(0),    32'd5);
    check("t1_peak1",     peak_of(1),    32'd0);
    check("t1_not_empty", bus.not_empty, 32'b01);
    check("t1_throttle",  bus.throttle,  32'b01);

    // Retire all five; not_empty lingers one cycle after the last retire.
    repeat (5) drive(2'b00, 2'b01);
    check("t1_drained_cnt0",  cnt_of(0),     32'd0);
    check("t1_ne_linger",     bus.not_empty, 32'b01);
    check("t1_peak_held",     peak_of(0),    32'd5);
    drive(2'b00, 2'b00);
    check("t1_ne_clear",      bus.not_empty, 32'b00);
    bus.clr_peak = 1'b1;
    drive(2'b00, 2'b00);
    check("t1_peak_cleared",  peak_of(0),    32'd0);

    // ch1 at 3 with simultaneous incr/decr for ten cycles holds.
    repeat (3) drive(2'b10, 2'b00);
    check("t2_cnt1_pre",  cnt_of(1), 32'd3);
    repeat (10) drive(2'b10, 2'b10);
    check("t2_cnt1_hold", cnt_of(1),         32'd3);
    check("t2_peak1",     peak_of(1),        32'd3);
    check("t2_err_unf",   bus.err_underflow, 32'b00);
    check("t2_err_ovf",   bus.err_overflow,  32'b00);
    repeat (3) drive(2'b00, 2'b10);
    check("t2_cnt1_zero", cnt_of(1), 32'd0);

    // Throttle threshold of 4 on ch0.
    repeat (3) drive(2'b01, 2'b00);
    check("t3_thr_below", bus.throttle, 32'b00);
    drive(2'b01, 2'b00);
    check("t3_thr_at_max", bus.throttle, 32'b01);
    drive(2'b00, 2'b01);
    check("t3_thr_release", bus.throttle, 32'b00);
    check("t3_cnt0",        cnt_of(0),    32'd3);
    repeat (3) drive(2'b00, 2'b01);

    // Underflow on ch1: sticky, cleared by clr_err, a same-cycle new error wins.
    drive(2'b00, 2'b10);
    check("t4_cnt1",       cnt_of(1),         32'd0);
    check("t4_unf_set",    bus.err_underflow, 32'b10);
    drive(2'b00, 2'b00);
    check("t4_unf_sticky", bus.err_underflow, 32'b10);
    bus.clr_err = 1'b1;
    drive(2'b00, 2'b00);
    check("t4_unf_clr",    bus.err_underflow, 32'b00);
    bus.clr_err = 1'b1;
    drive(2'b00, 2'b10);
    check("t4_unf_wins",   bus.err_underflow, 32'b10);
    bus.clr_err = 1'b1;
    drive(2'b00, 2'b00);
    check("t4_unf_clr2",   bus.err_underflow, 32'b00);

    // Drain with ch1=2, ch0=1.
    drive(2'b11, 2'b00);
    drive(2'b10, 2'b00);
    check("t5_cnt_setup", bus.active_cnt, 32'b010_001);
    bus.drain_req = 1'b1;
    drive(2'b00, 2'b00);
    check("t5_thr_drain",  bus.throttle,  32'b11);
    check("t5_ack_early",  bus.drain_ack, 32'd0);
    drive(2'b00, 2'b11);
    check("t5_ack_partial", bus.drain_ack, 32'd0);
    drive(2'b00, 2'b10);
    check("t5_ack_set",     bus.drain_ack, 32'd1);
    check("t5_thr_drained", bus.throttle,  32'b11);
    drive(2'b01, 2'b00);
    check("t5_viol_cnt0",   cnt_of(0),     32'd1);
    check("t5_viol_ack",    bus.drain_ack, 32'd0);
    drive(2'b00, 2'b01);
    check("t5_reack",       bus.drain_ack, 32'd1);
    bus.drain_req = 1'b0;
    drive(2'b00, 2'b00);
    check("t5_release_ack", bus.drain_ack, 32'd0);
    check("t5_release_thr", bus.throttle,  32'b00);

    // Drain abandoned before empty returns to normal operation.
    bus.drain_req = 1'b1;
    drive(2'b01, 2'b00);
    check("t5_abort_thr_on", bus.throttle, 32'b11);
    bus.drain_req = 1'b0;
    drive(2'b00, 2'b00);
    check("t5_abort_thr_off", bus.throttle,  32'b00);
    check("t5_abort_ack",     bus.drain_ack, 32'd0);

    // Saturation of a 3-bit counter (ch0 currently 1).
    repeat (6) drive(2'b01, 2'b00);
    check("t6_cnt0_max",  cnt_of(0),        32'd7);
    check("t6_ovf_clear", bus.err_overflow, 32'b00);
    drive(2'b01, 2'b00);
    check("t6_cnt0_sat",  cnt_of(0),        32'd7);
    check("t6_ovf_set",   bus.err_overflow, 32'b01);
    check("t6_peak0",     peak_of(0),       32'd7);
    drive(2'b01, 2'b01);
    check("t6_both_at_max", cnt_of(0), 32'd7);

    // Reset in the middle of a drain dominates every other input.
    bus.drain_req = 1'b1;
    drive(2'b00, 2'b00);
    check("t6_draining_thr", bus.throttle, 32'b11);
    reset        = 1'b1;
    bus.clr_err  = 1'b0;
    bus.clr_peak = 1'b0;
    drive(2'b11, 2'b00);
    check_all_zero("t6_reset");
    reset         = 1'b0;
    bus.drain_req = 1'b0;
    drive(2'b00, 2'b00);
    check("t6_post_reset_thr", bus.throttle,  32'b00);
    check("t6_post_reset_ack", bus.drain_ack, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
